// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. One full-adder cell and a carry flop process
// one operand bit per clock, LSB first. Subtraction is a + ~b + 1, so the
// carry flop is preloaded with 1 and B is stored inverted.
//
// Handshake: start is a request that is accepted only when the block is idle
// (busy=0, done=0). Once accepted, busy stays high for WIDTH cycles and done
// then pulses for one cycle, when sum/cout/ovf take their new values. start
// is ignored while busy or done is high, and nothing is queued.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // state is kept as a named signal so checkers can bind to it
   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             s_bit;
   logic             c_nxt;
   logic             last_bit;

   // full-adder cell on the current LSBs plus the stored carry
   assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
   assign c_nxt    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // status outputs decoded from the state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // operand load, serial datapath and result capture on the final bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
         end
      end else if (state == RUN) begin
         res_sr <= {s_bit, res_sr[WIDTH-1:1]};
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         carry  <= c_nxt;
         // counter parks at WIDTH-1 on the last bit so it never wraps
         if (!last_bit) begin
            cnt <= cnt + CW'(1);
         end
         if (last_bit) begin
            sum  <= {s_bit, res_sr[WIDTH-1:1]};
            cout <= c_nxt;
            // carry into the MSB differs from carry out of it
            ovf  <= carry ^ c_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a WIDTH=8 instance for the directed
// table, random vectors and multi-cycle corner cases, and a WIDTH=16 instance
// for a long back-to-back run with start held high.
module tb_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // ---------------- WIDTH=16 instance ----------------
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input logic [31:0] x, input logic [31:0] y,
                       input logic s, output logic [31:0] rs, output logic rc,
                       output logic ro);
    longint m, ux, uy, r, sx, sy, sr;
    m  = (longint'(1) << w) - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    r  = s ? (ux - uy) : (ux + uy);
    rs = 32'(r & m);
    rc = s ? (ux >= uy) : (r > m);
    sx = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    sr = s ? (sx - sy) : (sx + sy);
    ro = (sr > ((longint'(1) << (w - 1)) - 1)) || (sr < -(longint'(1) << (w - 1)));
  endtask

  // ---------------- driver: one WIDTH=8 operation ----------------
  task automatic run8(input string tag, input logic s, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] es, input logic ec,
                      input logic eo);
    int lat;
    int bc;
    @(negedge clk);
    start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
    @(posedge clk);
    lat = 0;
    bc  = 0;
    while (lat < 40) begin
      @(negedge clk);
      // scramble inputs while running: they must not be sampled
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      sub8   = 1'($urandom);
      if (done8) break;
      if (busy8) bc++;
      @(posedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, " cout"}, {31'd0, cout8}, {31'd0, ec});
    check({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eo});
    @(negedge clk);
    check({tag, " done_one_cycle"}, {31'd0, done8}, 32'd0);
  endtask

  typedef struct {
    logic       s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t        tbl[5];
    logic [31:0] ms;
    logic        mc, mo;
    int          dcnt;
    int          cyc, last_done, consumed, finished;
    logic        prev_busy;
    logic [17:0] exp_v;
    logic [15:0] na, nb;
    logic        ns;

    tbl[0] = '{s: 1'b0, x: 8'h7F, y: 8'h01, es: 8'h80, ec: 1'b0, eo: 1'b1};
    tbl[1] = '{s: 1'b0, x: 8'hFF, y: 8'h01, es: 8'h00, ec: 1'b1, eo: 1'b0};
    tbl[2] = '{s: 1'b1, x: 8'h05, y: 8'h07, es: 8'hFE, ec: 1'b0, eo: 1'b0};
    tbl[3] = '{s: 1'b1, x: 8'h80, y: 8'h01, es: 8'h7F, ec: 1'b1, eo: 1'b1};
    tbl[4] = '{s: 1'b1, x: 8'h33, y: 8'h33, es: 8'h00, ec: 1'b1, eo: 1'b0};

    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst busy8", {31'd0, busy8}, 32'd0);
    check("rst done8", {31'd0, done8}, 32'd0);
    check("rst sum8", {24'd0, sum8}, 32'd0);
    check("rst cout8", {31'd0, cout8}, 32'd0);
    check("rst ovf8", {31'd0, ovf8}, 32'd0);
    check("rst busy16", {31'd0, busy16}, 32'd0);
    check("rst sum16", {16'd0, sum16}, 32'd0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 5; i++) begin
      run8($sformatf("tbl%0d", i), tbl[i].s, tbl[i].x, tbl[i].y,
           tbl[i].es, tbl[i].ec, tbl[i].eo);
    end

    // random WIDTH=8 vectors against the model
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rx, ry;
      logic       rsb;
      rx  = 8'($urandom);
      ry  = 8'($urandom);
      rsb = 1'($urandom);
      model(8, {24'd0, rx}, {24'd0, ry}, rsb, ms, mc, mo);
      run8($sformatf("rnd%0d", i), rsb, rx, ry, ms[7:0], mc, mo);
    end

    // start during RUN is ignored; sum holds the previous result while running
    run8("pre", 1'b0, 8'h10, 8'h05, 8'h15, 1'b0, 1'b0);
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("hold sum in run", {24'd0, sum8}, 32'h15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("ignore start dones", dcnt, 1);
    check("ignore start sum", {24'd0, sum8}, 32'h03);

    // reset in the middle of RUN
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun rst busy", {31'd0, busy8}, 32'd0);
    check("midrun rst done", {31'd0, done8}, 32'd0);
    check("midrun rst sum", {24'd0, sum8}, 32'd0);
    check("midrun rst cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    check("no done after rst", dcnt, 0);
    check("sum stays reset", {24'd0, sum8}, 32'd0);
    run8("post_rst", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // WIDTH=16 back-to-back with start held high
    na = 16'($urandom); nb = 16'($urandom); ns = 1'($urandom);
    @(negedge clk);
    a16 = na; b16 = nb; sub16 = ns; start16 = 1'b1;
    prev_busy = 1'b0;
    consumed  = 0;
    finished  = 0;
    last_done = -1;
    cyc       = 0;
    while (finished < 1000 && cyc < 1000 * 18 + 100) begin
      @(negedge clk);
      cyc++;
      if (busy16 && !prev_busy) begin
        model(16, {16'd0, na}, {16'd0, nb}, ns, ms, mc, mo);
        exp_q.push_back({ms[15:0], mc, mo});
        consumed++;
        na = 16'($urandom); nb = 16'($urandom); ns = 1'($urandom);
        a16 = na; b16 = nb; sub16 = ns;
        if (consumed == 1000) start16 = 1'b0;
      end
      if (done16) begin
        if (exp_q.size() == 0) begin
          check("b2b unexpected done", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("b2b op%0d", finished), {14'd0, sum16, cout16, ovf16},
                {14'd0, exp_v});
        end
        if (last_done >= 0) check("b2b done spacing", cyc - last_done, 18);
        last_done = cyc;
        finished++;
      end
      prev_busy = busy16;
    end
    check("b2b ops finished", finished, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result of the last completed operation.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for sub, 1 = no borrow (a >= b unsigned).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the last completed operation.

Function
REQ-013 The block SHALL be a bit-serial adder: one full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL:
  - latch a into the A shift register;
  - latch b (bitwise inverted when sub=1) into the B shift register;
  - set carry to sub;
  - clear the bit counter;
  - go to RUN.
REQ-016 Each RUN edge SHALL:
  - compute s = A[0]^B[0]^carry and carry' = majority(A[0], B[0], carry);
  - shift s into the MSB of the result shift register;
  - shift A and B right;
  - increment the counter.
REQ-017 The edge that processes bit WIDTH-1 SHALL:
  - load sum from the completed result;
  - load cout from carry';
  - load ovf from (carry into bit WIDTH-1) XOR carry';
  - go to DONE.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1, and busy SHALL be high between edges k and k+WIDTH.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing; a, b and sub SHALL NOT be sampled there.
REQ-021 sum, cout and ovf SHALL change only on entry to DONE and SHALL hold their values through IDLE and the following RUN.
REQ-022 Counter width SHALL be ceil(log2(WIDTH)) bits; it SHALL NOT wrap within an operation.
REQ-023 start held high continuously SHALL start a new operation on the first edge in IDLE after each DONE, giving back-to-back operations every WIDTH+2 cycles.

Reset
REQ-024 rst=1 SHALL immediately force:
  - state to IDLE;
  - busy=0, done=0;
  - sum=0, cout=0, ovf=0;
  - carry, counter and shift registers to 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of sum, cout or ovf beyond their reset values.
REQ-026 After rst deasserts, the first edge with start=1 SHALL begin an operation per REQ-015.

Verification
REQ-027 WIDTH=8, a=0x7F, b=0x01, sub=0, start at edge 0 -> done high after edge 8 only; sum=0x80, cout=0, ovf=1.
REQ-028 WIDTH=8, a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
REQ-029 WIDTH=8, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-030 Pulse start=1 with a=0x11 at edge 3 during a RUN started with a=0x01, b=0x02 -> second start ignored; single done; sum=0x03.
REQ-031 Assert rst at edge 4 of a RUN -> busy=0, done=0 and sum=0 at once; no done pulse follows; a new operation completes normally.
REQ-032 WIDTH=16, start held high, random operands for 1000 operations -> each sum/cout/ovf matches the reference model, with done every 18 cycles.
